// File: rtl/ppu_vram_ctrl.sv
// PPU VRAM responder: answers fetcher reads with 1-cycle latency and owns
// the CPU $2006/$2007 path (v, w, read buffer, internal palette RAM).
module ppu_vram_ctrl #(
  parameter bit MIRROR_VERTICAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rendering,
  input  logic [15:0] render_addr,
  output logic [7:0]  render_data,
  input  logic        cpu_addr_wr,
  input  logic        cpu_data_wr,
  input  logic        cpu_data_rd,
  input  logic        cpu_latch_clr,
  input  logic        inc32,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_busy,
  output logic [12:0] chr_addr,
  input  logic [7:0]  chr_data,
  output logic [10:0] ciram_addr,
  output logic        ciram_we,
  output logic [7:0]  ciram_din,
  input  logic [7:0]  ciram_dout
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WR_COMMIT  = 2'd1;
  localparam logic [1:0] S_RD_ISSUE   = 2'd2;
  localparam logic [1:0] S_RD_CAPTURE = 2'd3;

  localparam logic [1:0] R_NONE = 2'd0;
  localparam logic [1:0] R_CHR  = 2'd1;
  localparam logic [1:0] R_NT   = 2'd2;
  localparam logic [1:0] R_PAL  = 2'd3;

  function automatic logic [1:0] region_of(input logic [13:0] a);
    if (a < 14'h2000)      region_of = R_CHR;
    else if (a < 14'h3F00) region_of = R_NT;
    else                   region_of = R_PAL;
  endfunction

  // Sprite-palette entry 0 of each group shares storage with the background one.
  function automatic logic [4:0] pal_idx(input logic [13:0] a);
    if (a[4] && (a[1:0] == 2'b00)) pal_idx = {1'b0, a[3:0]};
    else                           pal_idx = a[4:0];
  endfunction

  function automatic logic [10:0] nt_addr(input logic [13:0] a);
    nt_addr = {(MIRROR_VERTICAL ? a[10] : a[11]), a[9:0]};
  endfunction

  logic [1:0]  state_q, state_d;
  logic [13:0] v_q, v_d;
  logic        w_q, w_d;
  logic [7:0]  rd_buf_q, rd_buf_d;
  logic [7:0]  cpu_dout_q, cpu_dout_d;
  logic [7:0]  din_q, din_d;
  logic        cpu_chr_q, cpu_chr_d;
  logic [1:0]  rsel_q;
  logic [5:0]  rpal_q;
  logic [5:0]  pal_q [32];

  logic [13:0] render_a_s;
  logic [13:0] v_inc_s;
  logic [13:0] cpu_ea_s;
  logic [13:0] port_a_s;
  logic [1:0]  v_region_s;
  logic        cpu_port_s;
  logic        commit_s;
  logic        v_bump_s;
  logic        unused_s;

  assign render_a_s = render_addr[13:0];
  assign v_inc_s    = v_q + (inc32 ? 14'd32 : 14'd1);
  assign v_region_s = region_of(v_q);
  assign cpu_port_s = !rendering && ((state_q == S_RD_ISSUE) || (state_q == S_WR_COMMIT));
  // Palette reads still fetch the nametable byte underneath into the buffer.
  assign cpu_ea_s   = ((state_q == S_RD_ISSUE) && (v_q >= 14'h3F00)) ? (v_q - 14'h1000) : v_q;
  assign port_a_s   = cpu_port_s ? cpu_ea_s : render_a_s;
  assign commit_s   = (state_q == S_WR_COMMIT) && !rendering;
  assign unused_s   = ^{render_addr[15:14], port_a_s[13]};

  assign chr_addr   = reset ? 13'd0 : port_a_s[12:0];
  assign ciram_addr = reset ? 11'd0 : nt_addr(port_a_s);
  assign ciram_we   = commit_s && (v_region_s == R_NT);
  assign ciram_din  = din_q;
  assign cpu_dout   = cpu_dout_q;
  assign cpu_busy   = (state_q != S_IDLE);

  always_comb begin
    case (rsel_q)
      R_CHR:   render_data = chr_data;
      R_NT:    render_data = ciram_dout;
      R_PAL:   render_data = {2'b00, rpal_q};
      default: render_data = 8'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rd_buf_d   = rd_buf_q;
    cpu_dout_d = cpu_dout_q;
    din_d      = din_q;
    cpu_chr_d  = cpu_chr_q;
    v_bump_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_data_wr) begin
          din_d = cpu_din;
          if (rendering) v_bump_s = 1'b1;
          else           state_d  = S_WR_COMMIT;
        end else if (cpu_data_rd) begin
          if (rendering) begin
            cpu_dout_d = rd_buf_q;
            v_bump_s   = 1'b1;
          end else begin
            cpu_dout_d = (v_region_s == R_PAL) ? {2'b00, pal_q[pal_idx(v_q)]} : rd_buf_q;
            state_d    = S_RD_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_COMMIT: begin
        v_bump_s = 1'b1;
        state_d  = S_IDLE;
      end
      S_RD_ISSUE: begin
        cpu_chr_d = (region_of(cpu_ea_s) == R_CHR);
        state_d   = S_RD_CAPTURE;
      end
      S_RD_CAPTURE: begin
        rd_buf_d = cpu_chr_q ? chr_data : ciram_dout;
        v_bump_s = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A $2006 write takes priority over the post-access increment.
  always_comb begin
    if (cpu_addr_wr) begin
      if (w_q) v_d = {v_q[13:8], cpu_din};
      else     v_d = {cpu_din[5:0], v_q[7:0]};
    end else if (v_bump_s) begin
      v_d = v_inc_s;
    end else begin
      v_d = v_q;
    end
    if (cpu_latch_clr)    w_d = 1'b0;
    else if (cpu_addr_wr) w_d = ~w_q;
    else                  w_d = w_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      v_q        <= 14'd0;
      w_q        <= 1'b0;
      rd_buf_q   <= 8'd0;
      cpu_dout_q <= 8'd0;
      din_q      <= 8'd0;
      cpu_chr_q  <= 1'b0;
      rsel_q     <= R_NONE;
      rpal_q     <= 6'd0;
      for (int i = 0; i < 32; i++) pal_q[i] <= 6'd0;
    end else begin
      state_q    <= state_d;
      v_q        <= v_d;
      w_q        <= w_d;
      rd_buf_q   <= rd_buf_d;
      cpu_dout_q <= cpu_dout_d;
      din_q      <= din_d;
      cpu_chr_q  <= cpu_chr_d;
      rsel_q     <= region_of(render_a_s);
      rpal_q     <= pal_q[pal_idx(render_a_s)];
      if (commit_s && (v_region_s == R_PAL)) pal_q[pal_idx(v_q)] <= din_q[5:0];
    end
  end

endmodule

// File: tb/tb_ppu_vram_ctrl.sv
// Directed bench for ppu_vram_ctrl with an address-level model of PPU memory
// checked every cycle, plus hand-computed literal expectations.
module tb_ppu_vram_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        rendering;
  logic [15:0] render_addr;
  logic [7:0]  render_data;
  logic        cpu_addr_wr, cpu_data_wr, cpu_data_rd, cpu_latch_clr, inc32;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_busy;
  logic [12:0] chr_addr;
  logic [7:0]  chr_data = 8'd0;
  logic [10:0] ciram_addr;
  logic        ciram_we;
  logic [7:0]  ciram_din;
  logic [7:0]  ciram_dout = 8'd0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ppu_vram_ctrl #(.MIRROR_VERTICAL(1'b1)) dut (
    .clk(clk), .reset(reset), .rendering(rendering),
    .render_addr(render_addr), .render_data(render_data),
    .cpu_addr_wr(cpu_addr_wr), .cpu_data_wr(cpu_data_wr), .cpu_data_rd(cpu_data_rd),
    .cpu_latch_clr(cpu_latch_clr), .inc32(inc32), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_busy(cpu_busy),
    .chr_addr(chr_addr), .chr_data(chr_data),
    .ciram_addr(ciram_addr), .ciram_we(ciram_we), .ciram_din(ciram_din),
    .ciram_dout(ciram_dout)
  );

  // External synchronous CHR ROM and CIRAM.
  logic [7:0] chr_mem   [8192];
  logic [7:0] ciram_mem [2048];
  always @(posedge clk) chr_data <= chr_mem[chr_addr];
  always @(posedge clk) begin
    if (ciram_we) ciram_mem[ciram_addr] <= ciram_din;
    ciram_dout <= ciram_mem[ciram_addr];
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: PPU address space view ----------------
  int         m_v = 0, m_w = 0, m_left = 0;
  bit         m_is_wr = 1'b0, m_rvalid = 1'b0, m_cpu_port, m_was_busy, m_bump;
  logic [7:0] m_rdbuf = 8'd0, m_dout = 8'd0, m_wdata = 8'd0, m_rexp = 8'd0;
  logic [5:0] m_pal [32];
  logic [7:0] m_nt  [2048];

  function automatic int nt_index(input int a);
    int nt, page;
    nt   = ((a - 'h2000) / 1024) % 4;
    page = nt % 2;
    return page * 1024 + a % 1024;
  endfunction

  function automatic int pal_slot(input int a);
    int i;
    i = a % 32;
    if (i >= 16 && i % 4 == 0) i = i - 16;
    return i;
  endfunction

  function automatic logic [7:0] mem_read(input int a);
    if (a < 'h2000)      return chr_mem[a[12:0]];
    else if (a < 'h3F00) return m_nt[nt_index(a)];
    else                 return {2'b00, m_pal[pal_slot(a)]};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_v = 0; m_w = 0; m_left = 0; m_rdbuf = 8'd0; m_dout = 8'd0; m_rvalid = 1'b0;
      for (int i = 0; i < 32; i++) m_pal[i] = 6'd0;
    end else begin
      m_cpu_port = !rendering && ((m_is_wr && m_left == 1) || (!m_is_wr && m_left == 2));
      m_rvalid   = !m_cpu_port;
      if (!m_cpu_port) m_rexp = mem_read(int'(render_addr[13:0]));
      m_was_busy = (m_left > 0);
      m_bump     = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_bump = 1'b1;
          if (m_is_wr) begin
            if (!rendering) begin
              if (m_v >= 'h3F00)      m_pal[pal_slot(m_v)] = m_wdata[5:0];
              else if (m_v >= 'h2000) m_nt[nt_index(m_v)]  = m_wdata;
            end
          end else begin
            m_rdbuf = mem_read(m_v >= 'h3F00 ? m_v - 'h1000 : m_v);
          end
        end
      end
      if (!m_was_busy) begin
        if (cpu_data_wr) begin
          if (rendering) m_bump = 1'b1;
          else begin m_is_wr = 1'b1; m_left = 1; m_wdata = cpu_din; end
        end else if (cpu_data_rd) begin
          if (rendering) begin m_dout = m_rdbuf; m_bump = 1'b1; end
          else begin
            m_dout  = (m_v >= 'h3F00) ? mem_read(m_v) : m_rdbuf;
            m_is_wr = 1'b0; m_left = 2;
          end
        end
      end
      if (cpu_addr_wr) begin
        if (m_w != 0) m_v = (m_v & 'h3F00) | int'(cpu_din);
        else          m_v = ((int'(cpu_din) & 'h3F) << 8) | (m_v & 'hFF);
        m_w = (m_w != 0) ? 0 : 1;
      end else if (m_bump) begin
        m_v = (m_v + (inc32 ? 32 : 1)) % 'h4000;
      end
      if (cpu_latch_clr) m_w = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_busy", 16'(cpu_busy), 16'd0);
      check("rst_we", 16'(ciram_we), 16'd0);
      check("rst_dout", 16'(cpu_dout), 16'd0);
      check("rst_rdata", 16'(render_data), 16'd0);
    end else begin
      check("busy", 16'(cpu_busy), 16'(m_left > 0));
      check("ciram_we", 16'(ciram_we),
            16'(m_is_wr && m_left == 1 && !rendering && m_v >= 'h2000 && m_v < 'h3F00));
      check("cpu_dout", 16'(cpu_dout), 16'(m_dout));
      if (m_rvalid) check("render_data", 16'(render_data), 16'(m_rexp));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic addr_wr(input logic [7:0] d);
    cpu_din = d; cpu_addr_wr = 1'b1; tick(); cpu_addr_wr = 1'b0;
  endtask

  task automatic set_v(input logic [13:0] a);
    addr_wr({2'b00, a[13:8]});
    addr_wr(a[7:0]);
  endtask

  task automatic data_wr(input logic [7:0] d);
    cpu_din = d; cpu_data_wr = 1'b1; tick(); cpu_data_wr = 1'b0; tick();
  endtask

  task automatic data_rd(output logic [7:0] got);
    cpu_data_rd = 1'b1; tick(); cpu_data_rd = 1'b0; got = cpu_dout; tick(); tick();
  endtask

  task automatic render_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
    render_addr = a; tick();
    check(name, 16'(render_data), 16'(exp));
  endtask

  logic [7:0] g;

  initial begin
    for (int i = 0; i < 8192; i++) chr_mem[i] = 8'(i * 7 + 3);
    chr_mem[13'h0123] = 8'h5A;
    chr_mem[13'h0124] = 8'hA5;
    chr_mem[13'h0000] = 8'hC3;
    for (int i = 0; i < 2048; i++) begin ciram_mem[i] = 8'd0; m_nt[i] = 8'd0; end
    for (int i = 0; i < 32; i++) m_pal[i] = 6'd0;
    reset = 1'b1; rendering = 1'b0; render_addr = 16'd0;
    cpu_addr_wr = 1'b0; cpu_data_wr = 1'b0; cpu_data_rd = 1'b0;
    cpu_latch_clr = 1'b0; inc32 = 1'b0; cpu_din = 8'd0;
    repeat (3) tick();
    check("reset_chr_addr", 16'(chr_addr), 16'd0);
    check("reset_ciram_addr", 16'(ciram_addr), 16'd0);
    check("reset_dout", 16'(cpu_dout), 16'd0);
    reset = 1'b0;
    tick();

    rendering = 1'b1;
    render_chk("chr_0123", 16'h0123, 8'h5A);
    render_chk("chr_0124", 16'h0124, 8'hA5);
    rendering = 1'b0;

    set_v(14'h2405); data_wr(8'h77);
    render_chk("nt_2005", 16'h2005, 8'h00);
    render_chk("nt_2C05", 16'h2C05, 8'h77);
    render_chk("nt_2405", 16'h2405, 8'h77);
    render_chk("nt_2805", 16'h2805, 8'h00);

    set_v(14'h2000); data_wr(8'h11); data_wr(8'h22);
    set_v(14'h2000);
    data_rd(g); check("rdbuf_1st", 16'(g), 16'h0000);
    data_rd(g); check("rdbuf_2nd", 16'(g), 16'h0011);
    data_rd(g); check("rdbuf_3rd", 16'(g), 16'h0022);
    data_wr(8'h99);
    render_chk("v_end_2003", 16'h2003, 8'h99);

    set_v(14'h2F00); data_wr(8'h3C);
    set_v(14'h3F10); data_wr(8'h2C);
    set_v(14'h3F00);
    data_rd(g); check("pal_read_alias", 16'(g), 16'h002C);
    set_v(14'h2000);
    data_rd(g); check("pal_rdbuf_2F00", 16'(g), 16'h003C);
    render_chk("pal_render_3F10", 16'h3F10, 8'h2C);

    inc32 = 1'b1;
    set_v(14'h3FE0); data_wr(8'h15);
    data_rd(g);
    data_rd(g); check("v_wrap_chr0", 16'(g), 16'h00C3);
    render_chk("pal_3FE0_idx0", 16'h3F00, 8'h15);
    inc32 = 1'b0;

    set_v(14'h2010);
    rendering = 1'b1;
    cpu_din = 8'h55; cpu_data_wr = 1'b1; tick(); cpu_data_wr = 1'b0;
    check("rend_we_low", 16'(ciram_we), 16'd0);
    check("rend_not_busy", 16'(cpu_busy), 16'd0);
    tick();
    rendering = 1'b0;
    data_wr(8'h66);
    render_chk("rend_drop_2010", 16'h2010, 8'h00);
    render_chk("rend_inc_2011", 16'h2011, 8'h66);
    rendering = 1'b1;
    data_rd(g); check("rend_rd_buf", 16'(g), 16'h00E3);
    rendering = 1'b0;

    set_v(14'h2100);
    cpu_din = 8'hAA; cpu_data_wr = 1'b1; cpu_data_rd = 1'b1; tick();
    cpu_data_rd = 1'b0; cpu_din = 8'hBB; tick();
    cpu_data_wr = 1'b0; tick();
    render_chk("wr_wins_2100", 16'h2100, 8'hAA);
    render_chk("busy_ignored_2101", 16'h2101, 8'h00);
    data_wr(8'hCC);
    render_chk("busy_v_2101", 16'h2101, 8'hCC);

    addr_wr(8'h21);
    cpu_din = 8'h30; cpu_addr_wr = 1'b1; cpu_latch_clr = 1'b1; tick();
    cpu_addr_wr = 1'b0; cpu_latch_clr = 1'b0;
    data_wr(8'hAB);
    render_chk("wclr_coincide_2130", 16'h2130, 8'hAB);
    addr_wr(8'h23);
    cpu_latch_clr = 1'b1; tick(); cpu_latch_clr = 1'b0;
    set_v(14'h2131); data_wr(8'hCD);
    render_chk("wclr_alone_2131", 16'h2131, 8'hCD);

    set_v(14'h2040);
    cpu_din = 8'hEE; cpu_data_wr = 1'b1; tick(); cpu_data_wr = 1'b0;
    check("wc_we_before_rst", 16'(ciram_we), 16'd1);
    reset = 1'b1; #1;
    check("wc_rst_we", 16'(ciram_we), 16'd0);
    check("wc_rst_busy", 16'(cpu_busy), 16'd0);
    check("wc_rst_dout", 16'(cpu_dout), 16'd0);
    tick();
    reset = 1'b0;
    tick();
    render_chk("rst_abort_2040", 16'h2040, 8'h00);
    data_rd(g); check("rst_rdbuf0", 16'(g), 16'h0000);
    data_rd(g); check("rst_v0_chr", 16'(g), 16'h00C3);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
